// File: rtl/arm_cmd_responder_if.sv
// ARM-side command/data handshake bundle for arm_cmd_responder.
// The ARM drives through the master modport; the FPGA responder uses the slave modport.
interface arm_cmd_responder_if;
    logic [31:0]   arm_to_fpga_cmd;
    logic          arm_to_fpga_cmd_valid;
    logic          fpga_to_arm_done;
    logic          fpga_to_arm_done_read;
    logic          arm_to_fpga_data_valid;
    logic          arm_to_fpga_data_ready;
    logic [1023:0] arm_to_fpga_data;
    logic          fpga_to_arm_data_valid;
    logic          fpga_to_arm_data_ready;
    logic [1023:0] fpga_to_arm_data;

    modport master (
        output arm_to_fpga_cmd,
        output arm_to_fpga_cmd_valid,
        output fpga_to_arm_done_read,
        output arm_to_fpga_data_valid,
        output arm_to_fpga_data,
        output fpga_to_arm_data_ready,
        input  fpga_to_arm_done,
        input  arm_to_fpga_data_ready,
        input  fpga_to_arm_data_valid,
        input  fpga_to_arm_data
    );

    modport slave (
        input  arm_to_fpga_cmd,
        input  arm_to_fpga_cmd_valid,
        input  fpga_to_arm_done_read,
        input  arm_to_fpga_data_valid,
        input  arm_to_fpga_data,
        input  fpga_to_arm_data_ready,
        output fpga_to_arm_done,
        output arm_to_fpga_data_ready,
        output fpga_to_arm_data_valid,
        output fpga_to_arm_data
    );
endinterface

// File: rtl/arm_cmd_responder.sv
// FPGA endpoint of the ARM command/data protocol: READ/COMPUTE/WRITE with done handshake.
// Optional WAIT timeout abort is enabled by defining ARM_IF_TIMEOUT_EN.
module arm_cmd_responder #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 resetn,
    arm_cmd_responder_if.slave   arm,
    output logic                 core_start,
    input  logic                 core_done,
    output logic [1023:0]        core_in,
    input  logic [1023:0]        core_out,
    output logic [3:0]           leds
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RX    = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_TX    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          err_flag;
    logic          next_err;
    logic          load_in;
    logic          load_out;
    logic          timeout_hit;
    logic [1023:0] in_reg;
    logic [1023:0] out_reg;

`ifdef ARM_IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Held at zero outside WAIT so every WAIT visit starts counting afresh
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            err_flag <= 1'b0;
        end else begin
            state    <= next_state;
            err_flag <= next_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            in_reg  <= '0;
            out_reg <= '0;
        end else begin
            if (load_in) begin
                in_reg <= arm.arm_to_fpga_data;
            end
            if (load_out) begin
                out_reg <= core_out;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_err   = err_flag;
        load_in    = 1'b0;
        load_out   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arm.arm_to_fpga_cmd_valid) begin
                    next_err = 1'b0;
                    case (arm.arm_to_fpga_cmd)
                        32'd0:   next_state = ST_RX;
                        32'd1:   next_state = ST_START;
                        32'd2:   next_state = ST_TX;
                        default: begin
                            next_err   = 1'b1;
                            next_state = ST_DONE;
                        end
                    endcase
                end
            end
            ST_RX: begin
                if (arm.arm_to_fpga_data_valid) begin
                    load_in    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_START: begin
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the timeout edge still wins
                if (core_done) begin
                    load_out   = 1'b1;
                    next_state = ST_DONE;
                end else if (timeout_hit) begin
                    next_err   = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_TX: begin
                if (arm.fpga_to_arm_data_ready) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm.fpga_to_arm_done_read) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign arm.arm_to_fpga_data_ready = (state == ST_RX);
    assign arm.fpga_to_arm_data_valid = (state == ST_TX);
    assign arm.fpga_to_arm_done       = (state == ST_DONE);
    assign arm.fpga_to_arm_data       = out_reg;
    assign core_start                 = (state == ST_START);
    assign core_in                    = in_reg;
    assign leds                       = {err_flag, state};

endmodule

// File: tb/tb_arm_cmd_responder.sv
// Testbench for arm_cmd_responder: directed protocol scenarios plus randomized inputs
// checked every cycle against a command-level reference model.
module tb_arm_cmd_responder;

    localparam int TB_TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          core_start;
    logic          core_done;
    logic [1023:0] core_in;
    logic [1023:0] core_out;
    logic [3:0]    leds;

    arm_cmd_responder_if arm_bus ();

    arm_cmd_responder #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .arm        (arm_bus),
        .core_start (core_start),
        .core_done  (core_done),
        .core_in    (core_in),
        .core_out   (core_out),
        .leds       (leds)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: protocol phase numbered by its LED code, plus the two data registers
    int            m_code = 0;
    logic [1023:0] m_in   = '0;
    logic [1023:0] m_out  = '0;
    bit            m_err  = 1'b0;
    int            m_wait = 0;

    task automatic checkOutput(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (low 128b) at %0t", name, act[127:0], exp[127:0], $time);
        end
    endtask

    always @(posedge clk) begin
        if (!resetn) begin
            m_code = 0;
            m_in   = '0;
            m_out  = '0;
            m_err  = 1'b0;
            m_wait = 0;
        end else begin
            case (m_code)
                0: if (arm_bus.arm_to_fpga_cmd_valid) begin
                    m_err = 1'b0;
                    if (arm_bus.arm_to_fpga_cmd == 0)      m_code = 1;
                    else if (arm_bus.arm_to_fpga_cmd == 1) m_code = 2;
                    else if (arm_bus.arm_to_fpga_cmd == 2) m_code = 4;
                    else begin
                        m_err  = 1'b1;
                        m_code = 5;
                    end
                end
                1: if (arm_bus.arm_to_fpga_data_valid) begin
                    m_in   = arm_bus.arm_to_fpga_data;
                    m_code = 5;
                end
                2: begin
                    m_code = 3;
                    m_wait = 0;
                end
                3: if (core_done) begin
                    m_out  = core_out;
                    m_code = 5;
                end else begin
                    m_wait++;
`ifdef ARM_IF_TIMEOUT_EN
                    if (m_wait == TB_TIMEOUT) begin
                        m_err  = 1'b1;
                        m_code = 5;
                    end
`endif
                end
                4: if (arm_bus.fpga_to_arm_data_ready) m_code = 5;
                5: if (arm_bus.fpga_to_arm_done_read) m_code = 0;
                default: m_code = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("ready", arm_bus.arm_to_fpga_data_ready, m_code == 1);
            checkOutput("start", core_start, m_code == 2);
            checkOutput("valid", arm_bus.fpga_to_arm_data_valid, m_code == 4);
            checkOutput("done", arm_bus.fpga_to_arm_done, m_code == 5);
            checkOutput("leds", leds, {m_err, 3'(m_code)});
            checkOutput("core_in", core_in, m_in);
            checkOutput("out_data", arm_bus.fpga_to_arm_data, m_out);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] cmd);
        arm_bus.arm_to_fpga_cmd       = cmd;
        arm_bus.arm_to_fpga_cmd_valid = 1'b1;
        tick();
        arm_bus.arm_to_fpga_cmd_valid = 1'b0;
    endtask

    task automatic ackDone;
        int n = 0;
        while (!arm_bus.fpga_to_arm_done && n < 100) begin
            tick();
            n++;
        end
        checkOutput("done_seen", arm_bus.fpga_to_arm_done, 1'b1);
        arm_bus.fpga_to_arm_done_read = 1'b1;
        tick();
        arm_bus.fpga_to_arm_done_read = 1'b0;
    endtask

    logic [1023:0] read_val;
    logic [1023:0] res_val;
    int            ready_cycles;
    int            lat;
    int            starts;
    int            done_t;
    int            vcycles;
    int            wait_cycles;

    initial begin
        resetn                          = 1'b0;
        arm_bus.arm_to_fpga_cmd         = '0;
        arm_bus.arm_to_fpga_cmd_valid   = 1'b0;
        arm_bus.fpga_to_arm_done_read   = 1'b0;
        arm_bus.arm_to_fpga_data_valid  = 1'b0;
        arm_bus.arm_to_fpga_data        = '0;
        arm_bus.fpga_to_arm_data_ready  = 1'b0;
        core_done                       = 1'b0;
        core_out                        = '0;
        read_val = 1024'h0123456789abcdef;
        read_val = read_val << 640;
        res_val  = 1024'hA5;

        tick();
        chk_en = 1'b1;
        checkOutput("reset_leds", leds, 4'h0);
        tick();
        resetn = 1'b1;

        // READ with data already valid
        arm_bus.arm_to_fpga_data       = read_val;
        arm_bus.arm_to_fpga_data_valid = 1'b1;
        applyStimulus(32'd0);
        ready_cycles = 0;
        lat = 1;
        for (int i = 0; i < 20 && !arm_bus.fpga_to_arm_done; i++) begin
            if (arm_bus.arm_to_fpga_data_ready) ready_cycles++;
            tick();
            lat++;
        end
        arm_bus.arm_to_fpga_data_valid = 1'b0;
        checkOutput("read_ready_cycles", ready_cycles, 1);
        checkOutput("read_latency", lat, 2);
        checkOutput("read_core_in", core_in, read_val);
        checkOutput("read_done_leds", leds, 4'h5);
        tick();
        tick();
        checkOutput("read_done_hold", arm_bus.fpga_to_arm_done, 1'b1);
        ackDone();
        checkOutput("read_idle_leds", leds, 4'h0);

        // COMPUTE, core answers 7 cycles after start; stray cmd_valid while waiting
        applyStimulus(32'd1);
        starts = 0;
        done_t = 0;
        for (int t = 1; t <= 40; t++) begin
            if (core_start) starts++;
            if (arm_bus.fpga_to_arm_done) begin
                done_t = t;
                break;
            end
            if (t == 5) checkOutput("compute_wait_leds", leds, 4'h3);
            core_done = (t == 8);
            core_out  = (t == 8) ? res_val : '0;
            arm_bus.arm_to_fpga_cmd_valid = (t == 4);
            arm_bus.arm_to_fpga_cmd       = 32'd2;
            tick();
        end
        core_done = 1'b0;
        arm_bus.arm_to_fpga_cmd_valid = 1'b0;
        checkOutput("compute_start_pulses", starts, 1);
        checkOutput("compute_done_cycle", done_t, 9);
        checkOutput("compute_result", arm_bus.fpga_to_arm_data, res_val);
        ackDone();

        // WRITE, ready already high
        arm_bus.fpga_to_arm_data_ready = 1'b1;
        applyStimulus(32'd2);
        checkOutput("write_valid", arm_bus.fpga_to_arm_data_valid, 1'b1);
        checkOutput("write_data", arm_bus.fpga_to_arm_data, res_val);
        tick();
        checkOutput("write_done", arm_bus.fpga_to_arm_done, 1'b1);
        ackDone();

        // WRITE, ready delayed 3 cycles
        arm_bus.fpga_to_arm_data_ready = 1'b0;
        applyStimulus(32'd2);
        vcycles = 0;
        for (int t = 1; t <= 20; t++) begin
            if (arm_bus.fpga_to_arm_done) break;
            if (arm_bus.fpga_to_arm_data_valid) begin
                vcycles++;
                checkOutput("write_stable", arm_bus.fpga_to_arm_data, res_val);
            end
            arm_bus.fpga_to_arm_data_ready = (t >= 4);
            tick();
        end
        arm_bus.fpga_to_arm_data_ready = 1'b0;
        checkOutput("write_valid_cycles", vcycles, 4);
        ackDone();

`ifdef ARM_IF_TIMEOUT_EN
        // COMPUTE with a core that never answers
        applyStimulus(32'd1);
        wait_cycles = 0;
        for (int t = 0; t < 200 && !arm_bus.fpga_to_arm_done; t++) begin
            if (leds[2:0] == 3'd3) wait_cycles++;
            tick();
        end
        checkOutput("timeout_wait_cycles", wait_cycles, TB_TIMEOUT);
        checkOutput("timeout_leds", leds, 4'hD);
        checkOutput("timeout_out_kept", arm_bus.fpga_to_arm_data, res_val);
        ackDone();
`endif

        // Illegal command sets the error flag; the next command clears it
        applyStimulus(32'h7);
        checkOutput("bad_cmd_leds", leds, 4'hD);
        checkOutput("bad_cmd_done", arm_bus.fpga_to_arm_done, 1'b1);
        ackDone();
        checkOutput("bad_cmd_idle_leds", leds, 4'h8);
        arm_bus.arm_to_fpga_data_valid = 1'b1;
        applyStimulus(32'd0);
        checkOutput("err_cleared_leds", leds, 4'h1);
        tick();
        arm_bus.arm_to_fpga_data_valid = 1'b0;
        ackDone();

        // Reset in the middle of RX
        applyStimulus(32'd0);
        checkOutput("rx_ready", arm_bus.arm_to_fpga_data_ready, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checkOutput("rst_leds", leds, 4'h0);
        checkOutput("rst_ready", arm_bus.arm_to_fpga_data_ready, 1'b0);
        checkOutput("rst_done", arm_bus.fpga_to_arm_done, 1'b0);
        checkOutput("rst_core_in", core_in, '0);
        checkOutput("rst_out", arm_bus.fpga_to_arm_data, '0);
        arm_bus.fpga_to_arm_data_ready = 1'b1;
        applyStimulus(32'd2);
        checkOutput("rst_write_valid", arm_bus.fpga_to_arm_data_valid, 1'b1);
        checkOutput("rst_write_data", arm_bus.fpga_to_arm_data, '0);
        ackDone();
        arm_bus.fpga_to_arm_data_ready = 1'b0;

        // Randomized inputs, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            resetn                         = ($urandom_range(0, 199) != 0);
            arm_bus.arm_to_fpga_cmd_valid  = ($urandom_range(0, 3) == 0);
            arm_bus.arm_to_fpga_cmd        = ($urandom_range(0, 7) != 0) ? 32'($urandom_range(0, 2)) : $urandom;
            arm_bus.arm_to_fpga_data_valid = ($urandom_range(0, 2) == 0);
            arm_bus.fpga_to_arm_data_ready = ($urandom_range(0, 2) == 0);
            arm_bus.fpga_to_arm_done_read  = ($urandom_range(0, 2) == 0);
            core_done                      = ($urandom_range(0, 5) == 0);
            for (int w = 0; w < 32; w++) begin
                arm_bus.arm_to_fpga_data[w*32 +: 32] = $urandom;
                core_out[w*32 +: 32]                 = $urandom;
            end
            tick();
        end

        resetn                         = 1'b1;
        arm_bus.arm_to_fpga_cmd_valid  = 1'b0;
        arm_bus.arm_to_fpga_data_valid = 1'b0;
        arm_bus.fpga_to_arm_data_ready = 1'b0;
        arm_bus.fpga_to_arm_done_read  = 1'b0;
        core_done                      = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
